// File: rtl/syn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : syn_pkg
// Purpose  : Shared types and default timing for the sync-word link
//            (transmitter side and the slave-side receiver it feeds).
// Revision : 1.0 - initial release
// ============================================================================
package syn_pkg;

  // Transmitter frame sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    GUARD = 2'd3
  } syn_state_e;

  localparam int SYN_WORD_W    = 8;
  // Receiver detects start after START+1 = 3 high cycles
  localparam int SYN_START_CYC = 3;
  // Receiver bit period BAUD_DIV+1
  localparam int SYN_BIT_CYC   = 5;
  // Shortest guard that lets the receiver return to idle before a new start
  localparam int SYN_GUARD_MIN = 5;

  // Largest of three timing values, used to size the shared cycle counter
  function automatic int syn_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/syn_tx_buf.sv
`default_nettype none
// ============================================================================
// Module   : syn_tx_buf
// Purpose  : One-entry holding register with valid/ready on the write side.
//            The frame sequencer empties it with a single-cycle read strobe.
// Revision : 1.0 - initial release
// ============================================================================
module syn_tx_buf
  import syn_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  input  logic [SYN_WORD_W-1:0] wr_data_i,
  input  logic                  rd_i,
  output logic                  full_o,
  output logic [SYN_WORD_W-1:0] data_o
);

  logic                  full_q;
  logic [SYN_WORD_W-1:0] data_q;

  // Read only happens when full and write only when empty, so the two never collide
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (rd_i) begin
      full_q <= 1'b0;
    end else if (wr_valid_i && !full_q) begin
      full_q <= 1'b1;
      data_q <= wr_data_i;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/syn_tx.sv
`default_nettype none
// ============================================================================
// Module   : syn_tx
// Purpose  : Serial sync-word transmitter. Frames each byte as a high start
//            pulse, 8 data bits MSB first, and a low guard gap.
// Options  : SYN_TX_REPEAT_EN - resend the last byte after REPEAT_CYC idle
//            cycles with an empty buffer.
// Revision : 1.0 - initial release
// ============================================================================
module syn_tx
  import syn_pkg::*;
#(
  parameter int START_CYC  = SYN_START_CYC,
  parameter int BIT_CYC    = SYN_BIT_CYC,
  parameter int GUARD_CYC  = 8
`ifdef SYN_TX_REPEAT_EN
  ,
  parameter int REPEAT_CYC = 1000
`endif
) (
  input  logic                  clk_10M,
  input  logic                  rst,
  input  logic                  tx_valid,
  input  logic [SYN_WORD_W-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  data_to_slave,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = $clog2(syn_max3(START_CYC, BIT_CYC, GUARD_CYC) + 1);
  localparam logic [CW-1:0] c_START_LAST = CW'(START_CYC - 1);
  localparam logic [CW-1:0] c_BIT_LAST   = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] c_GUARD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] c_GUARD_PRE  = CW'(GUARD_CYC - 2);

  syn_state_e            state_q;
  logic [CW-1:0]         cyc_q;
  logic [2:0]            bit_q;
  logic [SYN_WORD_W-1:0] shift_q;
  logic                  line_q;
  logic                  done_q;

  logic                  buf_full;
  logic [SYN_WORD_W-1:0] buf_data;
  logic                  drain_d;
  logic                  start_d;
  logic [SYN_WORD_W-1:0] start_byte_d;

  // A buffered byte is consumed on the same edge the frame starts
  assign drain_d = (state_q == IDLE) && buf_full;

  syn_tx_buf u_buf (
    .clk_i      (clk_10M),
    .rst_i      (rst),
    .wr_valid_i (tx_valid),
    .wr_data_i  (tx_data),
    .rd_i       (drain_d),
    .full_o     (buf_full),
    .data_o     (buf_data)
  );

`ifdef SYN_TX_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC + 1);
  localparam logic [RW-1:0] c_REP_LAST = RW'(REPEAT_CYC - 1);

  logic [RW-1:0]         idle_q;
  logic [SYN_WORD_W-1:0] last_q;
  logic                  last_vld_q;
  logic                  rep_d;

  // Repeat only fires with an empty buffer, so a fresh byte always wins
  assign rep_d        = (state_q == IDLE) && !buf_full && last_vld_q && (idle_q == c_REP_LAST);
  assign start_d      = drain_d || rep_d;
  assign start_byte_d = buf_full ? buf_data : last_q;

  // Track idle time and remember the byte of every frame that starts
  always_ff @(posedge clk_10M) begin
    if (rst) begin
      idle_q     <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (start_d) begin
      idle_q     <= '0;
      last_q     <= start_byte_d;
      last_vld_q <= 1'b1;
    end else if ((state_q == IDLE) && !buf_full) begin
      idle_q <= (idle_q == c_REP_LAST) ? '0 : idle_q + 1'b1;
    end
  end
`else
  assign start_d      = drain_d;
  assign start_byte_d = buf_data;
`endif

  // Frame sequencer: start pulse, MSB-first data bits, guard gap
  always_ff @(posedge clk_10M) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_d) begin
            state_q <= START;
            shift_q <= start_byte_d;
            line_q  <= 1'b1;
            cyc_q   <= '0;
          end
        end
        START: begin
          if (cyc_q == c_START_LAST) begin
            state_q <= DATA;
            line_q  <= shift_q[SYN_WORD_W-1];
            cyc_q   <= '0;
            bit_q   <= '0;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        DATA: begin
          if (cyc_q == c_BIT_LAST) begin
            cyc_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= GUARD;
              line_q  <= 1'b0;
              done_q  <= (GUARD_CYC == 1);
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= {shift_q[SYN_WORD_W-2:0], 1'b0};
              line_q  <= shift_q[SYN_WORD_W-2];
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        GUARD: begin
          if (cyc_q == c_GUARD_LAST) begin
            state_q <= IDLE;
            cyc_q   <= '0;
          end else begin
            cyc_q  <= cyc_q + 1'b1;
            // Pulse lands on the final guard cycle
            done_q <= (cyc_q == c_GUARD_PRE);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready      = ~buf_full;
  assign data_to_slave = line_q;
  assign busy          = (state_q != IDLE);
  assign frame_done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_syn_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_syn_tx
// Purpose  : Self-checking bench for syn_tx. Stimulus pushes expected bytes
//            into a queue; a line monitor rebuilds each frame and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_syn_tx;

  localparam int START = 3;
  localparam int BITC  = 5;
  localparam int FLEN  = 51;

  logic       clk_10M = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       data_to_slave;
  logic       busy;
  logic       frame_done;

`ifdef SYN_TX_REPEAT_EN
  syn_tx #(.REPEAT_CYC(100)) dut (
`else
  syn_tx dut (
`endif
    .clk_10M       (clk_10M),
    .rst           (rst),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .data_to_slave (data_to_slave),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #50 clk_10M = ~clk_10M;

  int cyc = 0;
  always @(posedge clk_10M) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  int frames = 0;
  int acc_cyc = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  // Compare one captured frame against the next expected byte
  function automatic void frame_eval(input logic [FLEN-1:0] ln, input logic [FLEN-1:0] fd);
    logic [7:0]      got;
    logic [7:0]      e;
    logic [FLEN-1:0] el;
    logic [FLEN-1:0] ef;
    for (int i = 0; i < 8; i++) got[7-i] = ln[START + i*BITC + BITC/2];
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_frame: got byte 0x%02h expected no frame", got);
    end else begin
      e = exp_q.pop_front();
      check("frame_byte", {56'd0, got}, {56'd0, e});
      for (int i = 0; i < FLEN; i++) begin
        if (i < START) el[i] = 1'b1;
        else if (i < START + 8*BITC) el[i] = e[7 - (i - START)/BITC];
        else el[i] = 1'b0;
      end
      ef = '0;
      ef[FLEN-1] = 1'b1;
      check("frame_line", {13'd0, ln}, {13'd0, el});
      check("frame_done", {13'd0, fd}, {13'd0, ef});
    end
  endfunction

  // Line monitor: a high sample while idle opens a frame of FLEN samples
  bit              m_act = 1'b0;
  int              m_idx = 0;
  logic [FLEN-1:0] m_line;
  logic [FLEN-1:0] m_fd;
  always @(negedge clk_10M) begin
    if (rst) begin
      m_act = 1'b0;
      m_idx = 0;
    end else begin
      if (!m_act && data_to_slave === 1'b1) begin
        m_act = 1'b1;
        m_idx = 0;
        start_q.push_back(cyc);
      end
      if (m_act) begin
        m_line[m_idx] = data_to_slave;
        m_fd[m_idx]   = frame_done;
        m_idx++;
        if (m_idx == FLEN) begin
          m_act = 1'b0;
          frame_eval(m_line, m_fd);
          frames++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk_10M);
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready && n < 500) begin
      @(negedge clk_10M);
      n++;
    end
    if (!tx_ready) begin
      check("send_timeout", 64'd0, 64'd1);
      tx_valid = 1'b0;
    end else begin
      @(posedge clk_10M);
      #1;
      acc_cyc  = cyc;
      tx_valid = 1'b0;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n;
    n = 0;
    while (start_q.size() < target && n < budget) begin
      @(posedge clk_10M);
      #2;
      n++;
    end
    if (start_q.size() < target) check("start_timeout", start_q.size(), target);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames < target && n < budget) begin
      @(posedge clk_10M);
      #2;
      n++;
    end
    if (frames < target) check("frame_timeout", frames, target);
  endtask

  task automatic pulse_reset();
    @(posedge clk_10M);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk_10M);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int s0;
    int f0;
    int hi;
    repeat (2) @(posedge clk_10M);
    #1;
    check("rst_line",  data_to_slave, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_busy",  busy, 0);
    check("rst_done",  frame_done, 0);
    rst = 1'b0;

`ifdef SYN_TX_REPEAT_EN
    // Repeat: 0x7E resent every 151 cycles, then a queued 0x81 goes next
    s0 = start_q.size();
    f0 = frames;
    send(8'h7E);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'h7E);
    wait_starts(s0 + 3, 700);
    if (start_q.size() >= s0 + 3) begin
      check("rep_period1", start_q[s0+1] - start_q[s0], 151);
      check("rep_period2", start_q[s0+2] - start_q[s0+1], 151);
    end
    send(8'h81);
    wait_starts(s0 + 4, 200);
    if (start_q.size() >= s0 + 4) check("rep_new_wins", start_q[s0+3] - start_q[s0+2], 52);
    wait_frames(f0 + 4, 200);
    pulse_reset();
    repeat (20) @(posedge clk_10M);
    #1;
    check("frame_starts", start_q.size(), 4);
`else
    // 1: single 0xA5 frame, line rises one cycle after acceptance
    f0 = frames;
    send(8'hA5);
    wait_starts(1, 100);
    if (start_q.size() >= 1) check("t1_latency", start_q[0] - acc_cyc, 1);
    wait_frames(f0 + 1, 100);

    // 2: 0xFF then 0x00 back-to-back, second accepted while busy
    s0 = start_q.size();
    f0 = frames;
    send(8'hFF);
    send(8'h00);
    repeat (10) @(posedge clk_10M);
    #1;
    check("t2_ready_full", tx_ready, 0);
    check("t2_busy", busy, 1);
    wait_starts(s0 + 2, 200);
    if (start_q.size() >= s0 + 2) check("t2_period", start_q[s0+1] - start_q[s0], 52);
    check("t2_ready_drained", tx_ready, 1);
    wait_frames(f0 + 2, 200);

    // 3: 0x3C offered against a full buffer is dropped; 0x12 goes out intact
    f0 = frames;
    send(8'h55);
    send(8'h12);
    @(negedge clk_10M);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    hi = 0;
    repeat (10) begin
      @(negedge clk_10M);
      if (tx_ready) hi++;
    end
    tx_valid = 1'b0;
    check("t3_ready_low", hi, 0);
    wait_frames(f0 + 2, 200);

    // 4: reset mid-frame aborts 0xC3; 0x5A follows cleanly
    s0 = start_q.size();
    f0 = frames;
    send(8'hC3);
    wait_starts(s0 + 1, 100);
    repeat (18) @(posedge clk_10M);
    pulse_reset();
    check("t4_line",  data_to_slave, 0);
    check("t4_busy",  busy, 0);
    check("t4_ready", tx_ready, 1);
    send(8'h5A);
    wait_frames(f0 + 1, 100);

    repeat (60) @(posedge clk_10M);
    #1;
    check("frame_starts", start_q.size(), 7);
`endif
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/syn_tx.md
Name: syn_tx

Overview:
- Serial sync-word transmitter. It sits directly upstream of the slave-side sync receiver and drives its single-wire input data_to_slave.
- It accepts 8-bit sync-time bytes through a valid/ready handshake and holds one byte in a one-entry buffer.
- Each byte is framed as: idle low, a high start pulse, 8 data bits MSB first at a fixed bit period, then a low guard gap.
- The default timing matches the receiver: start detection after 3 high cycles, and a bit period of BAUD_DIV+1 = 5 cycles.

Parameters:
- START_CYC, 3: cycles data_to_slave is held high for the start pulse (receiver START+1).
- BIT_CYC, 5: cycles per data bit (receiver BAUD_DIV+1).
- GUARD_CYC, 8: low cycles after the last bit before the next frame may start. Minimum 5 at default timing, so the receiver is idle before the next start.
- REPEAT_CYC, 1000: idle cycles before an automatic resend. Used only with SYN_TX_REPEAT_EN.

Ports:
- clk_10M  input  1  system clock (10 MHz)
- rst  input  1  synchronous, active-high reset
- tx_valid  input  1  tx_data is valid this cycle
- tx_data  input  8  sync-time byte to send
- tx_ready  output  1  holding buffer is empty; a byte is accepted on tx_valid & tx_ready at posedge
- data_to_slave  output  1  registered serial line to the receiver
- busy  output  1  FSM not in IDLE
- frame_done  output  1  one-cycle pulse on the last GUARD cycle

Behaviour:
- One clock, clk_10M. Reset is synchronous and active-high.
- Reset values: data_to_slave=0, tx_ready=1, busy=0, frame_done=0. The buffer is emptied and the FSM goes to IDLE.
- Reset mid-frame aborts the frame. The line is low on the cycle after the reset edge.
- Holding buffer:
  - buf_full is a register; tx_ready = ~buf_full.
  - A byte is accepted at posedge N when tx_valid & tx_ready. buf_full=1 after N.
  - tx_valid while tx_ready=0 is ignored; the data is not latched and no error is raised.
- IDLE: line=0. If buf_full at a posedge:
  - copy the buffer into shift_reg;
  - clear buf_full;
  - go to START;
  - drive line=1 from that edge.
- Latency: a byte accepted at edge N drives line high after edge N+1.
- START: line=1 for exactly START_CYC cycles, then DATA.
- DATA:
  - line = shift_reg[7], then [6] ... [0].
  - Each bit is held BIT_CYC cycles; cyc_cnt runs 0..BIT_CYC-1 and bit_cnt 0..7.
  - After bit 0 completes, go to GUARD.
- GUARD: line=0 for GUARD_CYC cycles. frame_done=1 on the final GUARD cycle, then IDLE.
- Frame length is START_CYC + 8*BIT_CYC + GUARD_CYC = 51 cycles at defaults.
- Back-to-back frames: a buffered byte starts on the IDLE cycle after GUARD, so the frame period is 52 cycles.
- Concurrency with the buffer:
  - The buffer may be refilled while a frame is in flight.
  - When the FSM drains the buffer at edge M, tx_ready rises after M. A new accept can occur at M+1 at the earliest, so there is no same-edge read/write conflict.
- busy=1 in START, DATA and GUARD.
- Counter widths: cyc_cnt is sized to clog2(max(START_CYC, BIT_CYC, GUARD_CYC)+1); bit_cnt is 3 bits. Neither counter wraps; both are reset on every state entry.

Optional Feature:
- Macro SYN_TX_REPEAT_EN.
- When defined: last_byte is a register holding the most recent transmitted byte, valid after the first frame. If the FSM sits in IDLE with the buffer empty for REPEAT_CYC consecutive cycles, it resends last_byte as a normal frame. A buffered byte always wins over a repeat on the same edge. The idle counter clears on reset and on every frame start.
- When undefined: no last_byte register and no idle counter; the line stays low indefinitely in IDLE.

Decomposition:
- Package syn_pkg holds:
  - the state enum {IDLE, START, DATA, GUARD};
  - SYN_WORD_W=8;
  - default timing constants shared with the receiver (SYN_START_CYC=3, SYN_BIT_CYC=5, SYN_GUARD_MIN=5).
- Natural sub-module: syn_tx_buf, the one-entry holding register with valid/ready. The FSM, shifter and counters stay in syn_tx.

Test Plan:
1. Reset, then tx_data=0xA5 accepted at edge 0 → line high on cycles 1-3, then bits 1,0,1,0,0,1,0,1 at 5 cycles each on cycles 4-43, low for 44-51, frame_done on cycle 51; loopback into the receiver gives syn_time=0xA5.
2. 0xFF then 0x00 sent back-to-back (second accepted while busy) → tx_ready low from acceptance until the second frame starts; frame starts 52 cycles apart; receiver decodes 0xFF then 0x00 with no false start.
3. tx_valid held during a full buffer with tx_data=0x3C → not accepted, tx_ready=0; the previously buffered 0x12 is transmitted intact.
4. rst asserted at cycle 20 of a 0xC3 frame → line=0, busy=0, tx_ready=1 next cycle; a following 0x5A is sent and decoded correctly.
5. SYN_TX_REPEAT_EN with REPEAT_CYC=100: send 0x7E and go idle → the frame repeats every 51+100 cycles; a new 0x81 queued during a repeat goes out next.
